vec16_index_encoder: RTL and testbench
======================================

// Module: vec16_index_encoder
// PURPOSE
//  Sequential 16-to-4 index encoder, the inverse of the one-hot 4-to-16 decode path.
//  Accepts a 16-bit multi-hot vector over a valid/ready handshake and emits the 4-bit
//  index of every set bit, lowest index first, one index per output handshake.
//  Sits between request-mask producers and index-based consumers (mux selects, decoders).
// PARAMETERS
//  WIDTH  16  input vector width; only 16 is supported
//  IDXW   4   index width, $clog2(WIDTH); derived, do not override
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous reset, active low
//  in_valid   in   1      in_vec is valid
//  in_ready   out  1      encoder can accept a vector
//  in_vec     in   16     multi-hot input vector
//  out_valid  out  1      out_idx, out_last and out_empty are valid
//  out_ready  in   1      downstream accepts the current beat
//  out_idx    out  4      index of the current set bit
//  out_last   out  1      current beat is the final beat of this vector
//  out_empty  out  1      accepted vector was all-zero (single marker beat)
// BEHAVIOUR
//  - Clock/reset: one clock; reset asynchronous, active low. Reset sets state=IDLE,
//    vec_q=0, in_ready=1, out_valid=0, out_idx=0, out_last=0, out_empty=0.
//  - FSM states and transitions:
//    IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, register in_vec into vec_q
//      and go to EMIT.
//    EMIT: in_ready=0, out_valid=1, out_idx=ffs(vec_q).
//      On out_valid&&out_ready, clear bit out_idx in vec_q.
//      If out_last, return to IDLE. Otherwise stay in EMIT.
//  - out_last=1 when vec_q has exactly one set bit, or when the vector is empty.
//  - Latency: vector accepted at edge N gives first out_valid in cycle N+1.
//    With out_ready held high, one beat per cycle. k set bits take k cycles in EMIT.
//  - Throughput: in_ready returns to 1 in the cycle after the last beat's handshake.
//    There is no same-cycle accept while in EMIT, so a vector with k>0 set bits costs
//    k+1 cycles.
//  - All-zero vector: exactly one beat with out_empty=1, out_last=1, out_idx=0.
//  - Stall: while out_valid && !out_ready, out_idx, out_last and out_empty hold stable.
//    out_valid never drops until the last handshake.
//  - in_vec is sampled only on the handshake. Changes in EMIT are ignored.
//  - Reset asserted mid-burst aborts the burst immediately: the remaining bits are
//    discarded and all outputs take their reset values asynchronously.
// CONFIGURATION
//  VEC_ENC_POPCOUNT_EN defined:
//    - adds output port out_cnt[4:0], the number of set bits in the accepted vector
//      (0..16);
//    - out_cnt is registered at accept, holds constant for the whole burst, and is
//      valid with out_valid;
//    - reset value is 0.
//  VEC_ENC_POPCOUNT_EN undefined: port and logic are absent; all other behaviour is
//    identical.
// STRUCTURE
//  - Package vec_enc_pkg: WIDTH=16, IDXW=4, CNTW=5, typedef enum logic {IDLE, EMIT} state_t.
//  - Sub-module lsb_priority_enc: combinational 16-to-4 find-first-set.
//    Ports vec[15:0], idx[3:0], any. For vec=0 it gives idx=0, any=0.
//    Instantiated once on vec_q.
//  - Top level: FSM, vec_q register, bit-clear logic, last detect
//    (vec_q & (vec_q-1)) == 0, optional popcount.
// TESTING
//  1. in_vec=16'h0001, out_ready=1 -> one beat: idx=0, last=1, empty=0;
//     in_ready=1 the next cycle.
//  2. in_vec=16'h8421, out_ready=1 -> idx 0,5,10,15 on consecutive cycles, last only
//     on 15; out_cnt=4 if enabled.
//  3. in_vec=16'h0000 -> one beat: empty=1, last=1, idx=0; out_cnt=0 if enabled.
//  4. in_vec=16'hFFFF, out_ready toggling 1010... -> 16 beats, idx 0..15 in order;
//     outputs hold stable on every stalled cycle; out_cnt=16.
//  5. in_valid held high with 16'h0003 then 16'h0100 -> in_ready low for 2 EMIT cycles;
//     output sequence 0,1(last),8(last), with no lost or duplicate beats.
//  6. in_vec=16'hF000, rst_n pulled low after the first beat (idx 12) -> out_valid=0
//     and in_ready=1 immediately; after release, 16'h0010 gives idx 4, last=1.

Source files
------------

// File: rtl/vec_enc_pkg.sv
// Shared constants, FSM state type and popcount helper for the 16-to-4 index encoder.
// The optional out_cnt port is enabled by defining VEC_ENC_POPCOUNT_EN.
package vec_enc_pkg;

    localparam int WIDTH = 16;
    localparam int IDXW  = 4;
    localparam int CNTW  = 5;

    typedef enum logic {IDLE, EMIT} state_t;

    function automatic logic [CNTW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CNTW-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + CNTW'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/lsb_priority_enc.sv
// Combinational find-first-set: index of the lowest set bit of vec.
// An all-zero vector gives idx=0 and any=0.
module lsb_priority_enc
    import vec_enc_pkg::*;
(
    input  logic [WIDTH-1:0] vec,
    output logic [IDXW-1:0]  idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        any = |vec;
        // Scan from the top so the lowest set bit is the last one written.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i[IDXW-1:0];
            end
        end
    end

endmodule

// File: rtl/vec16_index_encoder.sv
// Sequential 16-to-4 index encoder: emits the index of every set bit of an accepted
// vector, lowest first, one per output handshake. VEC_ENC_POPCOUNT_EN adds out_cnt.
module vec16_index_encoder
    import vec_enc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last,
`ifdef VEC_ENC_POPCOUNT_EN
    output logic             out_empty,
    output logic [CNTW-1:0]  out_cnt
`else
    output logic             out_empty
`endif
);

    state_t           r_state;
    logic [WIDTH-1:0] r_vec_q;
    logic [IDXW-1:0]  w_ffs_idx;
    logic             w_any;
    logic             w_single;
    logic [WIDTH-1:0] w_clear_mask;

    lsb_priority_enc u_ffs (
        .vec (r_vec_q),
        .idx (w_ffs_idx),
        .any (w_any)
    );

    // Also true for an all-zero vector, which is emitted as a single marker beat.
    assign w_single     = (r_vec_q & (r_vec_q - WIDTH'(1))) == '0;
    assign w_clear_mask = WIDTH'(1) << w_ffs_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_vec_q <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_vec_q <= in_vec;
                        r_state <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        r_vec_q <= r_vec_q & ~w_clear_mask;
                        if (w_single) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef VEC_ENC_POPCOUNT_EN
    logic [CNTW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == IDLE && in_valid) begin
            r_cnt <= popcount(in_vec);
        end
    end

    assign out_cnt = r_cnt;
`endif

    // Outputs decode registered state only; nothing passes combinationally from inputs.
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == EMIT);
    assign out_idx   = (r_state == EMIT) ? w_ffs_idx : '0;
    assign out_last  = (r_state == EMIT) && w_single;
    assign out_empty = (r_state == EMIT) && !w_any;

endmodule

// File: tb/tb_vec16_index_encoder.sv
// Directed scoreboard bench for vec16_index_encoder.
module tb_vec16_index_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_vec;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        out_empty;
`ifdef VEC_ENC_POPCOUNT_EN
    logic [4:0]  out_cnt;
`endif

    typedef struct {
        logic [3:0] idx;
        logic       last;
        logic       empty;
        logic [4:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    vec16_index_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
`ifdef VEC_ENC_POPCOUNT_EN
        .out_empty (out_empty),
        .out_cnt   (out_cnt)
`else
        .out_empty (out_empty)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected beats for a vector: indices ascending, last on the final one.
    task automatic push_vec(input logic [15:0] v);
        exp_t e;
        int   n;
        int   seen;
        n = 0;
        for (int i = 0; i < 16; i++) if (v[i]) n++;
        if (n == 0) begin
            e.idx = 4'd0; e.last = 1'b1; e.empty = 1'b1; e.cnt = 5'd0;
            q.push_back(e);
        end else begin
            seen = 0;
            for (int i = 0; i < 16; i++) begin
                if (v[i]) begin
                    seen++;
                    e.idx = 4'(i); e.last = (seen == n); e.empty = 1'b0; e.cnt = 5'(n);
                    q.push_back(e);
                end
            end
        end
    endtask

    // Called at a negedge: compare the current beat with the queue head; pop on handshake.
    task automatic check_beat(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            chk({tag, "_queue_underflow"}, 32'(q.size()), 32'd1);
            return;
        end
        e = q[0];
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_idx"},   32'(out_idx),   32'(e.idx));
        chk({tag, "_last"},  32'(out_last),  32'(e.last));
        chk({tag, "_empty"}, 32'(out_empty), 32'(e.empty));
`ifdef VEC_ENC_POPCOUNT_EN
        chk({tag, "_cnt"},   32'(out_cnt),   32'(e.cnt));
`endif
        if (out_ready) void'(q.pop_front());
    endtask

    task automatic send(input string tag, input logic [15:0] v);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_accept_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_vec   = v;
        push_vec(v);
        @(negedge clk);
        in_valid = 1'b0;
        in_vec   = 16'($urandom);
    endtask

    task automatic drain(input string tag, input bit toggle);
        int guard;
        bit rdy;
        guard = 0;
        rdy   = 1'b1;
        while (q.size() > 0 && guard < 200) begin
            out_ready = rdy;
            chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
            check_beat(tag);
            in_vec = 16'($urandom);
            @(negedge clk);
            guard++;
            if (toggle) rdy = !rdy;
        end
        chk({tag, "_drained"}, 32'(q.size()), 32'd0);
        chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        out_ready = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = 16'h0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_idx",   32'(out_idx),   32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_out_empty", 32'(out_empty), 32'd0);
`ifdef VEC_ENC_POPCOUNT_EN
        chk("rst_out_cnt",   32'(out_cnt),   32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        send("t1", 16'h0001);
        drain("t1", 1'b0);

        send("t2", 16'h8421);
        drain("t2", 1'b0);

        send("t3", 16'h0000);
        drain("t3", 1'b0);

        send("t4", 16'hFFFF);
        drain("t4", 1'b1);

        // Back-to-back: in_valid stays high while the encoder is busy.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_vec    = 16'h0003;
        push_vec(16'h0003);
        @(negedge clk);
        chk("t5_busy0", 32'(in_ready), 32'd0);
        check_beat("t5_b0");
        in_vec = 16'h0100;
        push_vec(16'h0100);
        @(negedge clk);
        chk("t5_busy1", 32'(in_ready), 32'd0);
        check_beat("t5_b1");
        @(negedge clk);
        chk("t5_gap_valid", 32'(out_valid), 32'd0);
        chk("t5_gap_ready", 32'(in_ready),  32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check_beat("t5_b2");
        @(negedge clk);
        chk("t5_drained", 32'(q.size()), 32'd0);
        chk("t5_end_valid", 32'(out_valid), 32'd0);
        chk("t5_end_ready", 32'(in_ready),  32'd1);

        // Reset in the middle of a burst.
        send("t6", 16'hF000);
        out_ready = 1'b1;
        check_beat("t6_b0");
        @(negedge clk);
        chk("t6_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_ready", 32'(in_ready),  32'd1);
        chk("t6_rst_idx",   32'(out_idx),   32'd0);
        chk("t6_rst_last",  32'(out_last),  32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send("t6b", 16'h0010);
        drain("t6b", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
